// File: rtl/mips_pipelined_shift_unit_if.sv
// Handshake bundle for the pipelined shift unit.
// The master side issues operations and consumes results; the slave side is the unit.
interface mips_pipelined_shift_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [SHAMT_WIDTH-1:0] in_shamt;
  logic [2:0]             in_mode;
  logic [TAG_WIDTH-1:0]   in_tag;

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_carry;
  logic                   out_zero;
  logic                   out_illegal;
  logic [TAG_WIDTH-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_illegal, out_tag
  );
endinterface

// File: rtl/mips_pipelined_shift_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR/ROL) with carry/zero/illegal flags and a tag.
// The log2(width) binary stages are spread in order over LATENCY register stages.
module mips_pipelined_shift_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  mips_pipelined_shift_unit_if.slave bus
);
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
  localparam int PER_STAGE   = (SHAMT_WIDTH + LATENCY - 1) / LATENCY;

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;

  logic advance;
  logic accept;
  logic last_valid;
  logic zero_q;

  // All stages move together; a stalled output freezes the whole pipe, bubbles included.
  assign advance      = !last_valid || bus.out_ready;
  assign accept       = bus.in_valid && advance && !flush_i;
  assign bus.in_ready = advance;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      localparam int LO = gi * PER_STAGE;
      localparam int HI = ((gi + 1) * PER_STAGE < SHAMT_WIDTH) ? (gi + 1) * PER_STAGE : SHAMT_WIDTH;

      logic                   src_valid;
      logic [DATA_WIDTH-1:0]  src_data;
      logic [SHAMT_WIDTH-1:0] src_shamt;
      logic [2:0]             src_mode;
      logic                   src_sign;
      logic [TAG_WIDTH-1:0]   src_tag;
      logic                   src_carry;

      logic [DATA_WIDTH-1:0]  data_d;
      logic                   carry_d;
      logic [DATA_WIDTH-1:0]  spill;
      logic [SHAMT_WIDTH-1:0] shamt_bits;

      logic                   valid_q;
      logic [DATA_WIDTH-1:0]  data_q;
      logic [2:0]             mode_q;
      logic [TAG_WIDTH-1:0]   tag_q;
      logic                   carry_q;

      if (gi == 0) begin : g_head
        assign src_valid = accept;
        assign src_data  = bus.in_data;
        assign src_shamt = bus.in_shamt;
        assign src_mode  = bus.in_mode;
        assign src_sign  = bus.in_data[DATA_WIDTH-1];
        assign src_tag   = bus.in_tag;
        assign src_carry = 1'b0;
      end else begin : g_link
        assign src_valid = g_stage[gi-1].valid_q;
        assign src_data  = g_stage[gi-1].data_q;
        assign src_shamt = g_stage[gi-1].g_fwd.shamt_q;
        assign src_mode  = g_stage[gi-1].mode_q;
        assign src_sign  = g_stage[gi-1].g_fwd.sign_q;
        assign src_tag   = g_stage[gi-1].tag_q;
        assign src_carry = g_stage[gi-1].carry_q;
      end

      // Low shamt bits are applied first, so the last active binary stage leaves the final carry.
      always_comb begin
        data_d     = src_data;
        carry_d    = src_carry;
        spill      = '0;
        shamt_bits = '0;
        for (int k = LO; k < HI; k++) begin
          shamt_bits = src_shamt >> k;
          if (shamt_bits[0] && (src_mode <= MODE_ROL)) begin
            case (src_mode)
              MODE_SLL: begin
                spill   = data_d >> (DATA_WIDTH - (1 << k));
                carry_d = spill[0];
                data_d  = data_d << (1 << k);
              end
              MODE_SRL: begin
                spill   = data_d >> ((1 << k) - 1);
                carry_d = spill[0];
                data_d  = data_d >> (1 << k);
              end
              MODE_SRA: begin
                spill   = data_d >> ((1 << k) - 1);
                carry_d = spill[0];
                data_d  = (data_d >> (1 << k)) |
                          (src_sign ? ~({DATA_WIDTH{1'b1}} >> (1 << k)) : '0);
              end
              MODE_ROR: begin
                data_d  = (data_d >> (1 << k)) | (data_d << (DATA_WIDTH - (1 << k)));
                carry_d = data_d[DATA_WIDTH-1];
              end
              default: begin
                data_d  = (data_d << (1 << k)) | (data_d >> (DATA_WIDTH - (1 << k)));
                carry_d = data_d[0];
              end
            endcase
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          mode_q  <= '0;
          tag_q   <= '0;
          carry_q <= 1'b0;
        end else if (flush_i) begin
          valid_q <= 1'b0;
        end else if (advance) begin
          valid_q <= src_valid;
          data_q  <= data_d;
          mode_q  <= src_mode;
          tag_q   <= src_tag;
          carry_q <= carry_d;
        end
      end

      // Shift amount and sign are only needed by later stages.
      if (gi < LATENCY - 1) begin : g_fwd
        logic [SHAMT_WIDTH-1:0] shamt_q;
        logic                   sign_q;

        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            shamt_q <= '0;
            sign_q  <= 1'b0;
          end else if (!flush_i && advance) begin
            shamt_q <= src_shamt;
            sign_q  <= src_sign;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zero_q <= 1'b0;
    end else if (!flush_i && advance) begin
      zero_q <= (g_stage[LATENCY-1].data_d == '0);
    end
  end

  assign last_valid      = g_stage[LATENCY-1].valid_q;
  assign bus.out_valid   = last_valid;
  assign bus.out_data    = g_stage[LATENCY-1].data_q;
  assign bus.out_carry   = g_stage[LATENCY-1].carry_q;
  assign bus.out_zero    = zero_q;
  assign bus.out_illegal = (g_stage[LATENCY-1].mode_q > MODE_ROL);
  assign bus.out_tag     = g_stage[LATENCY-1].tag_q;
endmodule

// File: tb/tb_mips_pipelined_shift_unit.sv
// Directed bench: 32-bit/LATENCY=2 unit plus 64-bit units at LATENCY=1 and LATENCY=5.
module tb_mips_pipelined_shift_unit;
  logic clk;
  logic rst;
  logic flush;

  int checks = 0;
  int errors = 0;
  logic [3:0] tag_ctr = 4'd0;

  mips_pipelined_shift_unit_if #(.DATA_WIDTH(32), .TAG_WIDTH(4)) b32 ();
  mips_pipelined_shift_unit_if #(.DATA_WIDTH(64), .TAG_WIDTH(4)) b1 ();
  mips_pipelined_shift_unit_if #(.DATA_WIDTH(64), .TAG_WIDTH(4)) b5 ();

  mips_pipelined_shift_unit #(.DATA_WIDTH(32), .LATENCY(2), .TAG_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b32.slave));
  mips_pipelined_shift_unit #(.DATA_WIDTH(64), .LATENCY(1), .TAG_WIDTH(4)) dut_l1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b1.slave));
  mips_pipelined_shift_unit #(.DATA_WIDTH(64), .LATENCY(5), .TAG_WIDTH(4)) dut_l5 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated operation through the 32-bit unit, checking exact latency and all result fields.
  task automatic op32(input string tag, input logic [2:0] mode, input logic [31:0] data,
                      input logic [4:0] shamt, input logic [31:0] exp_data,
                      input logic exp_carry, input logic exp_ill);
    logic [3:0] t;
    t = tag_ctr;
    tag_ctr = tag_ctr + 4'd1;
    b32.in_valid = 1'b1;
    b32.in_mode  = mode;
    b32.in_data  = data;
    b32.in_shamt = shamt;
    b32.in_tag   = t;
    tick();
    b32.in_valid = 1'b0;
    chk({tag, " valid@1"}, b32.out_valid, 1'b0);
    tick();
    chk({tag, " valid@2"}, b32.out_valid, 1'b1);
    chk({tag, " data"}, b32.out_data, exp_data);
    chk({tag, " carry"}, b32.out_carry, exp_carry);
    chk({tag, " zero"}, b32.out_zero, exp_data == 32'd0);
    chk({tag, " illegal"}, b32.out_illegal, exp_ill);
    chk({tag, " tag"}, b32.out_tag, t);
    tick();
    chk({tag, " drained"}, b32.out_valid, 1'b0);
    $display("op32 %s mode=%0d data=%h shamt=%0d -> %h carry=%0b", tag, mode, data, shamt,
             b32.out_data, b32.out_carry);
  endtask

  // Same operation into both 64-bit units; LATENCY=1 answers after one edge, LATENCY=5 after five.
  task automatic op64(input string tag, input logic [2:0] mode, input logic [63:0] data,
                      input logic [5:0] shamt, input logic [63:0] exp_data, input logic exp_carry);
    logic [3:0] t;
    t = tag_ctr;
    tag_ctr = tag_ctr + 4'd1;
    b1.in_valid = 1'b1; b1.in_mode = mode; b1.in_data = data; b1.in_shamt = shamt; b1.in_tag = t;
    b5.in_valid = 1'b1; b5.in_mode = mode; b5.in_data = data; b5.in_shamt = shamt; b5.in_tag = t;
    tick();
    b1.in_valid = 1'b0;
    b5.in_valid = 1'b0;
    chk({tag, " L1 valid"}, b1.out_valid, 1'b1);
    chk({tag, " L1 data"}, b1.out_data, exp_data);
    chk({tag, " L1 carry"}, b1.out_carry, exp_carry);
    chk({tag, " L1 tag"}, b1.out_tag, t);
    chk({tag, " L5 valid@1"}, b5.out_valid, 1'b0);
    repeat (3) tick();
    chk({tag, " L5 valid@4"}, b5.out_valid, 1'b0);
    tick();
    chk({tag, " L5 valid@5"}, b5.out_valid, 1'b1);
    chk({tag, " L5 data"}, b5.out_data, exp_data);
    chk({tag, " L5 carry"}, b5.out_carry, exp_carry);
    chk({tag, " L5 tag"}, b5.out_tag, t);
    chk({tag, " L1 drained"}, b1.out_valid, 1'b0);
    tick();
    $display("op64 %s mode=%0d data=%h shamt=%0d -> L1 %h L5 %h", tag, mode, data, shamt,
             b1.out_data, b5.out_data);
  endtask

  function automatic logic [31:0] stream_in(input int i);
    return 32'(i + 1) << 8;
  endfunction

  function automatic logic [31:0] stream_exp(input int i);
    return (32'(i + 1) << 8) << i;
  endfunction

  initial begin
    int sent;
    int recv;
    bit prev_stall;
    bit stall;
    logic [31:0] held_data;
    logic [3:0]  held_tag;

    rst = 1'b1;
    flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_shamt = '0; b32.in_mode = '0; b32.in_tag = '0;
    b32.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_shamt = '0; b1.in_mode = '0; b1.in_tag = '0;
    b1.out_ready = 1'b1;
    b5.in_valid = 1'b0; b5.in_data = '0; b5.in_shamt = '0; b5.in_mode = '0; b5.in_tag = '0;
    b5.out_ready = 1'b1;
    repeat (3) tick();

    chk("reset out_valid", b32.out_valid, 1'b0);
    chk("reset out_data", b32.out_data, 32'd0);
    chk("reset out_carry", b32.out_carry, 1'b0);
    chk("reset out_zero", b32.out_zero, 1'b0);
    chk("reset out_illegal", b32.out_illegal, 1'b0);
    chk("reset out_tag", b32.out_tag, 4'd0);
    rst = 1'b0;
    #1;
    chk("reset in_ready", b32.in_ready, 1'b1);
    $display("reset released");

    op32("sll1",     3'd0, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1, 1'b0);
    op32("sll28",    3'd0, 32'h0000_00FF, 5'd28, 32'hF000_0000, 1'b1, 1'b0);
    op32("sra31",    3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op32("sra5",     3'd2, 32'h8000_0010, 5'd5,  32'hFC00_0000, 1'b1, 1'b0);
    op32("srl31",    3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0);
    // ROR carry is the result MSB: bit 31 of 0x1000_0000 is 0.
    op32("ror4",     3'd3, 32'h0000_0001, 5'd4,  32'h1000_0000, 1'b0, 1'b0);
    op32("ror1",     3'd3, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 1'b0);
    op32("rol1",     3'd4, 32'h8000_0000, 5'd1,  32'h0000_0001, 1'b1, 1'b0);
    op32("sll0",     3'd0, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A, 1'b0, 1'b0);
    op32("sra0",     3'd2, 32'h8000_00F0, 5'd0,  32'h8000_00F0, 1'b0, 1'b0);
    op32("rol0",     3'd4, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0);
    op32("srl_zero", 3'd1, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1'b0);
    op32("mode6",    3'd6, 32'h1234_5678, 5'd3,  32'h1234_5678, 1'b0, 1'b1);

    op64("sll64",  3'd0, 64'h8000_0000_0000_0001, 6'd1,  64'h0000_0000_0000_0002, 1'b1);
    op64("sra64",  3'd2, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    op64("srl64",  3'd1, 64'h8000_0000_0000_0000, 6'd63, 64'h0000_0000_0000_0001, 1'b0);

    // Back-to-back stream of 8 tagged ops with a 3-cycle output stall in the middle.
    sent = 0;
    recv = 0;
    prev_stall = 1'b0;
    held_data = '0;
    held_tag = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      stall = (cyc >= 4 && cyc < 7);
      b32.out_ready = !stall;
      b32.in_valid  = (sent < 8);
      b32.in_mode   = 3'd0;
      b32.in_data   = stream_in(sent);
      b32.in_shamt  = 5'(sent);
      b32.in_tag    = 4'(sent);
      #1;
      if (stall) begin
        chk("stream stall in_ready", b32.in_ready, 1'b0);
        chk("stream stall out_valid", b32.out_valid, 1'b1);
      end
      if (stall && prev_stall) begin
        chk("stream hold data", b32.out_data, held_data);
        chk("stream hold tag", b32.out_tag, held_tag);
      end
      if (b32.out_valid && b32.out_ready) begin
        chk("stream tag order", b32.out_tag, 4'(recv));
        chk("stream data", b32.out_data, stream_exp(recv));
        $display("stream recv tag=%0d data=%h", b32.out_tag, b32.out_data);
        recv++;
      end
      held_data = b32.out_data;
      held_tag = b32.out_tag;
      prev_stall = stall;
      if (b32.in_valid && b32.in_ready) sent++;
      tick();
    end
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    chk("stream count", 64'(recv), 64'd8);
    repeat (3) begin
      tick();
      chk("stream no duplicate", b32.out_valid, 1'b0);
    end

    // Flush with two ops in flight and a third presented in the flush cycle.
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_mode = 3'd0; b32.in_data = 32'h1; b32.in_shamt = 5'd1; b32.in_tag = 4'hA;
    tick();
    b32.in_tag = 4'hB;
    tick();
    chk("flush pre out_valid", b32.out_valid, 1'b1);
    b32.in_tag = 4'hC;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    b32.in_valid = 1'b0;
    chk("flush out_valid", b32.out_valid, 1'b0);
    b32.out_ready = 1'b1;
    b32.in_valid = 1'b1; b32.in_tag = 4'hD;
    flush = 1'b1;
    #1;
    chk("flush in_ready", b32.in_ready, 1'b1);
    tick();
    flush = 1'b0;
    b32.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("flush stays empty", b32.out_valid, 1'b0);
      tick();
    end
    $display("flush sequence done");

    // Same sequence with reset instead of flush.
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_mode = 3'd3; b32.in_data = 32'h0000_0011; b32.in_shamt = 5'd4; b32.in_tag = 4'h5;
    tick();
    b32.in_tag = 4'h6;
    tick();
    chk("rst pre out_valid", b32.out_valid, 1'b1);
    b32.in_tag = 4'h7;
    rst = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    chk("rst mid out_valid", b32.out_valid, 1'b0);
    chk("rst mid out_data", b32.out_data, 32'd0);
    chk("rst mid out_carry", b32.out_carry, 1'b0);
    chk("rst mid out_zero", b32.out_zero, 1'b0);
    chk("rst mid out_illegal", b32.out_illegal, 1'b0);
    chk("rst mid out_tag", b32.out_tag, 4'd0);
    rst = 1'b0;
    b32.out_ready = 1'b1;
    #1;
    chk("rst mid in_ready", b32.in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst stays empty", b32.out_valid, 1'b0);
    end
    $display("reset sequence done");

    op32("post_rst_sll", 3'd0, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
